// File: rtl/rule110_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rule110_checker                                               |
// | Purpose  : Passive checker for a Rule 110 automaton. It watches the      |
// |            automaton's load/data/q nets. Each cycle it rebuilds the      |
// |            expected state from its own one-cycle history and compares    |
// |            it with q. It reports mismatches, counts generations since    |
// |            the last load, and latches the first error location.          |
// | Ports    : clk, reset (sync, active-high)                                |
// |            load, data[WIDTH]   observed load strobe / load value         |
// |            q[WIDTH]            observed automaton state                  |
// |            checking            high while comparisons are active         |
// |            mismatch            one-cycle pulse per failing compare       |
// |            err                 sticky first-mismatch flag                |
// |            gen_count           generation of the last compared q         |
// |            first_err_gen/idx   generation / lowest cell of first error   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rule110_checker #(
   parameter int WIDTH = 512,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic [WIDTH-1:0]         data,
   input  logic [WIDTH-1:0]         q,
   output logic                     checking,
   output logic                     mismatch,
   output logic                     err,
   output logic [CNT_W-1:0]         gen_count,
   output logic [CNT_W-1:0]         first_err_gen,
   output logic [$clog2(WIDTH)-1:0] first_err_idx
);

   localparam int IDX_W = $clog2(WIDTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CHECK = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               h_load_q, h_load_d;
   logic [WIDTH-1:0]   h_data_q, h_data_d;
   logic [WIDTH-1:0]   h_q_q, h_q_d;
   logic               mismatch_q, mismatch_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   gen_count_q, gen_count_d;
   logic [CNT_W-1:0]   first_err_gen_q, first_err_gen_d;
   logic [IDX_W-1:0]   first_err_idx_q, first_err_idx_d;

   // History padded with a zero on each side so the edge cells see
   // out-of-range neighbours as 0 (no wrap-around).
   logic [WIDTH+1:0]   h_pad;
   logic [WIDTH-1:0]   next_gen;
   logic [WIDTH-1:0]   exp_q;
   logic [WIDTH-1:0]   diff;
   logic [IDX_W-1:0]   low_idx;
   logic [CNT_W-1:0]   gen_inc;

   assign h_pad = {1'b0, h_q_q, 1'b0};

   // Cell i: pad[i+2] = left (q[i+1]), pad[i+1] = centre, pad[i] = right (q[i-1]).
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign next_gen[i] = (h_pad[i+1] & ~h_pad[i+2]) | (h_pad[i+1] ^ h_pad[i]);
   end

   assign exp_q = h_load_q ? h_data_q : next_gen;
   assign diff  = q ^ exp_q;

   // Lowest set bit of diff; scanning downward lets the lowest index win.
   always_comb begin
      low_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (diff[i]) begin
            low_idx = IDX_W'(i);
         end
      end
   end

   assign gen_inc = (gen_count_q == {CNT_W{1'b1}}) ? gen_count_q
                                                   : gen_count_q + CNT_W'(1);

   always_comb begin
      state_d         = state_q;
      h_load_d        = load;
      h_data_d        = data;
      h_q_d           = q;
      mismatch_d      = 1'b0;
      err_d           = err_q;
      gen_count_d     = gen_count_q;
      first_err_gen_d = first_err_gen_q;
      first_err_idx_d = first_err_idx_q;

      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            mismatch_d  = |diff;
            gen_count_d = h_load_q ? '0 : gen_inc;
            if ((|diff) && !err_q) begin
               err_d           = 1'b1;
               first_err_gen_d = h_load_q ? '0 : gen_inc;
               first_err_idx_d = low_idx;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         h_load_q        <= 1'b0;
         h_data_q        <= '0;
         h_q_q           <= '0;
         mismatch_q      <= 1'b0;
         err_q           <= 1'b0;
         gen_count_q     <= '0;
         first_err_gen_q <= '0;
         first_err_idx_q <= '0;
      end else begin
         state_q         <= state_d;
         h_load_q        <= h_load_d;
         h_data_q        <= h_data_d;
         h_q_q           <= h_q_d;
         mismatch_q      <= mismatch_d;
         err_q           <= err_d;
         gen_count_q     <= gen_count_d;
         first_err_gen_q <= first_err_gen_d;
         first_err_idx_q <= first_err_idx_d;
      end
   end

   assign checking      = (state_q == ST_CHECK);
   assign mismatch      = mismatch_q;
   assign err           = err_q;
   assign gen_count     = gen_count_q;
   assign first_err_gen = first_err_gen_q;
   assign first_err_idx = first_err_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_rule110_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rule110_checker                                            |
// | Purpose  : Self-checking bench for rule110_checker. The bench plays the  |
// |            automaton by driving q, runs a vector table, then hand-written |
// |            reload and saturation sequences.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rule110_checker;

   localparam int W  = 64;
   localparam int CW = 4;
   localparam int IW = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load = 1'b0;
   logic [W-1:0]  data = '0;
   logic [W-1:0]  q = '0;
   logic          checking;
   logic          mismatch;
   logic          err;
   logic [CW-1:0] gen_count;
   logic [CW-1:0] first_err_gen;
   logic [IW-1:0] first_err_idx;

   int checks = 0;
   int errors = 0;

   rule110_checker #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk           (clk),
      .reset         (reset),
      .load          (load),
      .data          (data),
      .q             (q),
      .checking      (checking),
      .mismatch      (mismatch),
      .err           (err),
      .gen_count     (gen_count),
      .first_err_gen (first_err_gen),
      .first_err_idx (first_err_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          ld;
      logic [W-1:0]  dat;
      logic [W-1:0]  qv;
      logic          e_chk;
      logic          e_mm;
      logic          e_err;
      logic [CW-1:0] e_gen;
      logic [CW-1:0] e_feg;
      logic [IW-1:0] e_fei;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic rst, input logic ld,
                               input logic [W-1:0] dat, input logic [W-1:0] qv,
                               input logic chk, input logic mm, input logic er,
                               input int gen, input int feg, input int fei);
      vec_t v;
      v.rst = rst; v.ld = ld; v.dat = dat; v.qv = qv;
      v.e_chk = chk; v.e_mm = mm; v.e_err = er;
      v.e_gen = CW'(gen); v.e_feg = CW'(feg); v.e_fei = IW'(fei);
      vq.push_back(v);
   endfunction

   // Stimulus-side automaton: per-cell Rule 110, zero outside the array.
   function automatic logic [W-1:0] r110(input logic [W-1:0] s);
      logic [W-1:0] n;
      logic l, c, r;
      for (int i = 0; i < W; i++) begin
         l = (i == W - 1) ? 1'b0 : s[i+1];
         c = s[i];
         r = (i == 0) ? 1'b0 : s[i-1];
         n[i] = (c & ~l) | (c ^ r);
      end
      return n;
   endfunction

   task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic ld, input logic [W-1:0] d, input logic [W-1:0] qq);
      @(negedge clk);
      reset = r;
      load  = ld;
      data  = d;
      q     = qq;
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] top_bit;
   logic [W-1:0] cur;

   initial begin
      top_bit = '0;
      top_bit[W-1] = 1'b1;

      //    rst ld dat           q             chk mm err gen feg fei
      // Faithful run from a single seed cell: 1, 3, 7, 13, 31.
      add(1, 0, 0,             0,             0,  0, 0,  0,  0,  0);
      add(0, 1, 1,             0,             1,  0, 0,  0,  0,  0);
      add(0, 0, 0,             1,             1,  0, 0,  0,  0,  0);
      add(0, 0, 0,             3,             1,  0, 0,  1,  0,  0);
      add(0, 0, 0,             7,             1,  0, 0,  2,  0,  0);
      add(0, 0, 0,             13,            1,  0, 0,  3,  0,  0);
      add(0, 0, 0,             31,            1,  0, 0,  4,  0,  0);
      // Same run with 15 forced at generation 3; a later second fault
      // (58 instead of 59) must not move the first-error fields.
      add(1, 0, 0,             0,             0,  0, 0,  0,  0,  0);
      add(0, 1, 1,             0,             1,  0, 0,  0,  0,  0);
      add(0, 0, 0,             1,             1,  0, 0,  0,  0,  0);
      add(0, 0, 0,             3,             1,  0, 0,  1,  0,  0);
      add(0, 0, 0,             7,             1,  0, 0,  2,  0,  0);
      add(0, 0, 0,             15,            1,  1, 1,  3,  3,  1);
      add(0, 0, 0,             25,            1,  0, 1,  4,  3,  1);
      add(0, 0, 0,             58,            1,  1, 1,  5,  3,  1);
      add(0, 0, 0,             110,           1,  0, 1,  6,  3,  1);
      // Reset mid-CHECK with load on the same edge: nothing arms.
      add(1, 1, 1,             110,           0,  0, 0,  0,  0,  0);
      add(0, 0, 0,             5,             0,  0, 0,  0,  0,  0);
      add(0, 0, 0,             7,             0,  0, 0,  0,  0,  0);
      // Top cell alone: left neighbour reads 0 and no cell has a set
      // right neighbour, so it is a fixed point; a wrapping bit 0 would
      // expect bit 0 set and flag a mismatch.
      add(0, 1, top_bit,       0,             1,  0, 0,  0,  0,  0);
      add(0, 0, 0,             top_bit,       1,  0, 0,  0,  0,  0);
      add(0, 0, 0,             top_bit,       1,  0, 0,  1,  0,  0);
      add(0, 0, 0,             top_bit,       1,  0, 0,  2,  0,  0);

      foreach (vq[k]) begin
         step(vq[k].rst, vq[k].ld, vq[k].dat, vq[k].qv);
         cmp($sformatf("row%0d checking", k), W'(checking), W'(vq[k].e_chk));
         cmp($sformatf("row%0d mismatch", k), W'(mismatch), W'(vq[k].e_mm));
         cmp($sformatf("row%0d err", k), W'(err), W'(vq[k].e_err));
         cmp($sformatf("row%0d gen_count", k), W'(gen_count), W'(vq[k].e_gen));
         cmp($sformatf("row%0d first_err_gen", k), W'(first_err_gen), W'(vq[k].e_feg));
         cmp($sformatf("row%0d first_err_idx", k), W'(first_err_idx), W'(vq[k].e_fei));
      end

      // Reload mid-run with a prior error: fault at generation 2 on bit 4.
      step(1, 0, 0, 0);
      step(0, 1, 64'd56866875, 0);
      cur = 64'd56866875;
      step(0, 0, 0, cur);
      cmp("reload gen0", W'(gen_count), 0);
      for (int g = 1; g <= 5; g++) begin
         cur = r110(cur);
         if (g == 2) begin
            cur = cur ^ 64'h10;
         end
         step(0, 0, 0, cur);
         cmp($sformatf("reload g%0d gen_count", g), W'(gen_count), W'(g));
         cmp($sformatf("reload g%0d mismatch", g), W'(mismatch), W'(g == 2));
      end
      cmp("reload first_err_gen", W'(first_err_gen), 2);
      cmp("reload first_err_idx", W'(first_err_idx), 4);
      // Load sampled this edge; its comparison is the next one.
      cur = r110(cur);
      step(0, 1, 1, cur);
      cmp("reload load-edge gen_count", W'(gen_count), 6);
      step(0, 0, 0, 1);
      cmp("reload compare gen_count", W'(gen_count), 0);
      cmp("reload compare mismatch", W'(mismatch), 0);
      cmp("reload err kept", W'(err), 1);
      cmp("reload feg kept", W'(first_err_gen), 2);
      cmp("reload fei kept", W'(first_err_idx), 4);

      // Saturation: 20 generations on a 4-bit counter stop at 15.
      cur = 1;
      for (int g = 1; g <= 20; g++) begin
         cur = r110(cur);
         step(0, 0, 0, cur);
         cmp($sformatf("sat g%0d gen_count", g), W'(gen_count), W'((g > 15) ? 15 : g));
         cmp($sformatf("sat g%0d mismatch", g), W'(mismatch), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
